time_of_day_counter: RTL and testbench

TIME_OF_DAY_COUNTER -- requirements
Module: time_of_day_counter

---
 rtl/clock_pkg.sv | 42 ++++
 rtl/time_of_day_counter_if.sv | 30 +++
 rtl/bcd_digit_counter.sv | 28 ++
 rtl/time_of_day_counter.sv | 103 ++++++++++
 tb/tb_time_of_day_counter.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/clock_pkg.sv
// Shared widths, digit limits and reset values for the time-of-day counter.
// Also holds the hour sequencing helper used by the top level.
package clock_pkg;

    localparam int unsigned ONES_W      = 4;
    localparam int unsigned TENS_W      = 3;
    localparam int unsigned HR_TENS_W   = 2;

    localparam int unsigned ONES_LIMIT  = 9;
    localparam int unsigned TENS_LIMIT  = 5;
    localparam int unsigned HR_LIMIT_12 = 12;
    localparam int unsigned HR_LIMIT_24 = 23;

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_TICK,
        OP_SET
    } op_e;

    typedef struct packed {
        logic [HR_TENS_W-1:0] tens;
        logic [ONES_W-1:0]    ones;
    } hour_t;

    localparam hour_t RST_HR_12 = '{tens: 2'd1, ones: 4'd2};
    localparam hour_t RST_HR_24 = '{tens: 2'd0, ones: 4'd0};

    // 12-hour mode runs 12,01..11,12; 24-hour mode runs 00..23,00.
    function automatic hour_t next_hour(input hour_t cur, input logic twenty_four);
        logic [4:0] h;
        hour_t      r;
        h = 5'(cur.tens) * 5'd10 + 5'(cur.ones);
        if (twenty_four)
            h = (h == 5'(HR_LIMIT_24)) ? 5'd0 : h + 5'd1;
        else
            h = (h == 5'(HR_LIMIT_12)) ? 5'd1 : h + 5'd1;
        r.tens = HR_TENS_W'(h / 5'd10);
        r.ones = ONES_W'(h % 5'd10);
        return r;
    endfunction

endpackage

// File: rtl/time_of_day_counter_if.sv
// Control inputs and BCD time outputs of the time-of-day counter.
interface time_of_day_counter_if;

    logic                                TICK;
    logic                                RUN;
    logic                                SET_MIN;
    logic                                SET_HR;
    logic [clock_pkg::ONES_W-1:0]        SEC_ONES;
    logic [clock_pkg::TENS_W-1:0]        SEC_TENS;
    logic [clock_pkg::ONES_W-1:0]        MIN_ONES;
    logic [clock_pkg::TENS_W-1:0]        MIN_TENS;
    logic [clock_pkg::ONES_W-1:0]        HR_ONES;
    logic [clock_pkg::HR_TENS_W-1:0]     HR_TENS;
    logic                                PM;
    logic                                MIN_PULSE;
    logic                                DAY_PULSE;

    modport master (
        output TICK, RUN, SET_MIN, SET_HR,
        input  SEC_ONES, SEC_TENS, MIN_ONES, MIN_TENS, HR_ONES, HR_TENS,
        input  PM, MIN_PULSE, DAY_PULSE
    );

    modport slave (
        input  TICK, RUN, SET_MIN, SET_HR,
        output SEC_ONES, SEC_TENS, MIN_ONES, MIN_TENS, HR_ONES, HR_TENS,
        output PM, MIN_PULSE, DAY_PULSE
    );

endinterface

// File: rtl/bcd_digit_counter.sv
// Single mod-(LIMIT+1) digit, falling-edge clocked, with enable, sync clear and carry-out.
module bcd_digit_counter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned LIMIT = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] q,
    output logic             co
);

    logic at_limit;

    assign at_limit = (q == WIDTH'(LIMIT));
    assign co       = en & at_limit;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (en)
            q <= at_limit ? '0 : q + WIDTH'(1);
    end

endmodule

// File: rtl/time_of_day_counter.sv
// BCD time-of-day counter: seconds/minutes from digit counters, hours and PM locally.
// All state changes on the falling edge of CLK; CLEAR is an asynchronous active-low reset.
module time_of_day_counter
    import clock_pkg::*;
#(
    parameter bit TWENTY_FOUR = 1'b0
) (
    input  logic                  CLK,
    input  logic                  CLEAR,
    time_of_day_counter_if.slave  tod
);

    localparam hour_t HR_RST = TWENTY_FOUR ? RST_HR_24 : RST_HR_12;

    op_e   op;
    logic  tick_adv;
    logic  do_set_min;
    logic  do_set_hr;

    logic [ONES_W-1:0] sec_ones_q;
    logic [TENS_W-1:0] sec_tens_q;
    logic [ONES_W-1:0] min_ones_q;
    logic [TENS_W-1:0] min_tens_q;
    logic              sec_ones_co;
    logic              sec_wrap;
    logic              min_ones_co;
    logic              min_wrap;

    hour_t hr_q;
    logic  pm_q;
    logic  min_pulse_q;
    logic  day_pulse_q;
    logic  hr_adv;
    logic  at_eleven;
    logic  at_23;
    logic  day_roll;

    // Any set request wins over TICK for the whole cycle.
    always_comb begin
        op = OP_HOLD;
        if (tod.SET_MIN || tod.SET_HR)
            op = OP_SET;
        else if (tod.TICK && tod.RUN)
            op = OP_TICK;
    end

    assign tick_adv   = (op == OP_TICK);
    assign do_set_min = (op == OP_SET) && tod.SET_MIN;
    assign do_set_hr  = (op == OP_SET) && tod.SET_HR;

    bcd_digit_counter #(.WIDTH(ONES_W), .LIMIT(ONES_LIMIT)) u_sec_ones (
        .clk(CLK), .rst_n(CLEAR), .en(tick_adv), .clr(do_set_min),
        .q(sec_ones_q), .co(sec_ones_co)
    );

    bcd_digit_counter #(.WIDTH(TENS_W), .LIMIT(TENS_LIMIT)) u_sec_tens (
        .clk(CLK), .rst_n(CLEAR), .en(sec_ones_co), .clr(do_set_min),
        .q(sec_tens_q), .co(sec_wrap)
    );

    bcd_digit_counter #(.WIDTH(ONES_W), .LIMIT(ONES_LIMIT)) u_min_ones (
        .clk(CLK), .rst_n(CLEAR), .en(sec_wrap | do_set_min), .clr(1'b0),
        .q(min_ones_q), .co(min_ones_co)
    );

    bcd_digit_counter #(.WIDTH(TENS_W), .LIMIT(TENS_LIMIT)) u_min_tens (
        .clk(CLK), .rst_n(CLEAR), .en(min_ones_co), .clr(1'b0),
        .q(min_tens_q), .co(min_wrap)
    );

    // A minute wrap from SET_MIN must not carry, so only a ticked wrap feeds hours.
    assign hr_adv    = (tick_adv & min_wrap) | do_set_hr;
    assign at_eleven = (hr_q.tens == 2'd1) && (hr_q.ones == 4'd1);
    assign at_23     = (hr_q.tens == 2'd2) && (hr_q.ones == 4'd3);
    assign day_roll  = tick_adv & min_wrap & (TWENTY_FOUR ? at_23 : (at_eleven & pm_q));

    always_ff @(negedge CLK or negedge CLEAR) begin
        if (!CLEAR) begin
            hr_q        <= HR_RST;
            pm_q        <= 1'b0;
            min_pulse_q <= 1'b0;
            day_pulse_q <= 1'b0;
        end else begin
            if (hr_adv)
                hr_q <= next_hour(hr_q, TWENTY_FOUR);
            if (!TWENTY_FOUR && hr_adv && at_eleven)
                pm_q <= ~pm_q;
            min_pulse_q <= sec_wrap;
            day_pulse_q <= day_roll;
        end
    end

    assign tod.SEC_ONES  = sec_ones_q;
    assign tod.SEC_TENS  = sec_tens_q;
    assign tod.MIN_ONES  = min_ones_q;
    assign tod.MIN_TENS  = min_tens_q;
    assign tod.HR_ONES   = hr_q.ones;
    assign tod.HR_TENS   = hr_q.tens;
    assign tod.PM        = TWENTY_FOUR ? 1'b0 : pm_q;
    assign tod.MIN_PULSE = min_pulse_q;
    assign tod.DAY_PULSE = day_pulse_q;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Drives a 12-hour and a 24-hour instance with identical stimulus and checks both
// against a seconds-of-day model every cycle, plus literal expectations per scenario.
module tb_time_of_day_counter;

    logic CLK;
    logic CLEAR;
    bit   armed;
    int   checks;
    int   errors;

    int   t;
    bit   e_minp;
    bit   e_dayp;

    time_of_day_counter_if if12();
    time_of_day_counter_if if24();

    time_of_day_counter #(.TWENTY_FOUR(1'b0)) dut12 (.CLK(CLK), .CLEAR(CLEAR), .tod(if12));
    time_of_day_counter #(.TWENTY_FOUR(1'b1)) dut24 (.CLK(CLK), .CLEAR(CLEAR), .tod(if24));

    initial CLK = 1'b1;
    always #5 CLK = ~CLK;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Time of day held as seconds since midnight; both displays derive from it.
    always @(negedge CLK or negedge CLEAR) begin
        int h, m, s;
        if (!CLEAR) begin
            t = 0; e_minp = 0; e_dayp = 0;
        end else begin
            e_minp = 0; e_dayp = 0;
            if (if12.SET_MIN || if12.SET_HR) begin
                h = t / 3600; m = (t / 60) % 60; s = t % 60;
                if (if12.SET_MIN) begin m = (m + 1) % 60; s = 0; end
                if (if12.SET_HR) h = (h + 1) % 24;
                t = h * 3600 + m * 60 + s;
            end else if (if12.TICK && if12.RUN) begin
                t = (t + 1) % 86400;
                e_minp = (t % 60 == 0);
                e_dayp = (t == 0);
            end
        end
    end

    always @(posedge CLK) begin
        int h, hd, mn, sc;
        if (armed) begin
            h  = t / 3600; mn = (t / 60) % 60; sc = t % 60;
            hd = (h % 12 == 0) ? 12 : h % 12;
            check("m12_sec_ones", int'(if12.SEC_ONES), sc % 10);
            check("m12_sec_tens", int'(if12.SEC_TENS), sc / 10);
            check("m12_min_ones", int'(if12.MIN_ONES), mn % 10);
            check("m12_min_tens", int'(if12.MIN_TENS), mn / 10);
            check("m12_hr_ones",  int'(if12.HR_ONES),  hd % 10);
            check("m12_hr_tens",  int'(if12.HR_TENS),  hd / 10);
            check("m12_pm",       int'(if12.PM),       (h >= 12) ? 1 : 0);
            check("m12_min_pulse", int'(if12.MIN_PULSE), int'(e_minp));
            check("m12_day_pulse", int'(if12.DAY_PULSE), int'(e_dayp));
            check("m24_sec_ones", int'(if24.SEC_ONES), sc % 10);
            check("m24_sec_tens", int'(if24.SEC_TENS), sc / 10);
            check("m24_min_ones", int'(if24.MIN_ONES), mn % 10);
            check("m24_min_tens", int'(if24.MIN_TENS), mn / 10);
            check("m24_hr_ones",  int'(if24.HR_ONES),  h % 10);
            check("m24_hr_tens",  int'(if24.HR_TENS),  h / 10);
            check("m24_pm",       int'(if24.PM),       0);
            check("m24_min_pulse", int'(if24.MIN_PULSE), int'(e_minp));
            check("m24_day_pulse", int'(if24.DAY_PULSE), int'(e_dayp));
        end
    end

    task automatic drive(input bit tk, input bit rn, input bit sm, input bit sh);
        if12.TICK = tk; if12.RUN = rn; if12.SET_MIN = sm; if12.SET_HR = sh;
        if24.TICK = tk; if24.RUN = rn; if24.SET_MIN = sm; if24.SET_HR = sh;
    endtask

    // Inputs change just after the rising edge; outputs are read just after the falling edge.
    task automatic step(input bit tk, input bit rn, input bit sm, input bit sh);
        @(posedge CLK); #1;
        drive(tk, rn, sm, sh);
        @(negedge CLK); #1;
    endtask

    task automatic steps(input int n, input bit tk, input bit rn, input bit sm, input bit sh);
        for (int i = 0; i < n; i++) step(tk, rn, sm, sh);
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        drive(0, 0, 0, 0);
        #1 CLEAR = 1'b0;
        @(posedge CLK); #3 CLEAR = 1'b1;
    endtask

    task automatic lit12(input string nm, input int hr, input int mn, input int sc, input int pm);
        check({nm, "_12_hrt"}, int'(if12.HR_TENS),  hr / 10);
        check({nm, "_12_hro"}, int'(if12.HR_ONES),  hr % 10);
        check({nm, "_12_mnt"}, int'(if12.MIN_TENS), mn / 10);
        check({nm, "_12_mno"}, int'(if12.MIN_ONES), mn % 10);
        check({nm, "_12_sct"}, int'(if12.SEC_TENS), sc / 10);
        check({nm, "_12_sco"}, int'(if12.SEC_ONES), sc % 10);
        check({nm, "_12_pm"},  int'(if12.PM),       pm);
    endtask

    task automatic lit24(input string nm, input int hr, input int mn, input int sc);
        check({nm, "_24_hrt"}, int'(if24.HR_TENS),  hr / 10);
        check({nm, "_24_hro"}, int'(if24.HR_ONES),  hr % 10);
        check({nm, "_24_mnt"}, int'(if24.MIN_TENS), mn / 10);
        check({nm, "_24_mno"}, int'(if24.MIN_ONES), mn % 10);
        check({nm, "_24_sct"}, int'(if24.SEC_TENS), sc / 10);
        check({nm, "_24_sco"}, int'(if24.SEC_ONES), sc % 10);
        check({nm, "_24_pm"},  int'(if24.PM),       0);
    endtask

    task automatic pulses(input string nm, input int mp, input int dp);
        check({nm, "_12_minp"}, int'(if12.MIN_PULSE), mp);
        check({nm, "_12_dayp"}, int'(if12.DAY_PULSE), dp);
        check({nm, "_24_minp"}, int'(if24.MIN_PULSE), mp);
        check({nm, "_24_dayp"}, int'(if24.DAY_PULSE), dp);
    endtask

    initial begin
        checks = 0; errors = 0; armed = 0;
        CLEAR = 1'b1;
        drive(0, 0, 0, 0);
        #1 CLEAR = 1'b0;
        #1 armed = 1;
        #21 CLEAR = 1'b1;

        step(0, 0, 0, 0);
        lit12("reset", 12, 0, 0, 0);
        lit24("reset", 0, 0, 0);
        pulses("reset", 0, 0);

        // Minute rollover from 12:00:59.
        steps(59, 1, 1, 0, 0);
        lit12("pre_minroll", 12, 0, 59, 0);
        step(1, 1, 0, 0);
        lit12("minroll", 12, 1, 0, 0);
        lit24("minroll", 0, 1, 0);
        pulses("minroll", 1, 0);
        step(0, 1, 0, 0);
        pulses("minroll_after", 0, 0);

        // Hold at 03:15:20 with RUN low.
        do_reset();
        steps(3, 0, 0, 0, 1);
        steps(15, 0, 0, 1, 0);
        steps(20, 1, 1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 0, 0);
            pulses("hold", 0, 0);
        end
        lit12("hold", 3, 15, 20, 0);
        lit24("hold", 3, 15, 20);

        // Midnight rollover.
        do_reset();
        steps(23, 0, 0, 0, 1);
        steps(59, 0, 0, 1, 0);
        steps(59, 1, 1, 0, 0);
        lit12("pre_midnight", 11, 59, 59, 1);
        lit24("pre_midnight", 23, 59, 59);
        step(1, 1, 0, 0);
        lit12("midnight", 12, 0, 0, 0);
        lit24("midnight", 0, 0, 0);
        pulses("midnight", 1, 1);
        step(0, 1, 0, 0);
        pulses("midnight_after", 0, 0);

        // Simultaneous SET_MIN, SET_HR and TICK at 05:59:30.
        do_reset();
        steps(5, 0, 0, 0, 1);
        steps(59, 0, 0, 1, 0);
        steps(30, 1, 1, 0, 0);
        lit12("pre_prec", 5, 59, 30, 0);
        step(1, 1, 1, 1);
        lit12("prec", 6, 0, 0, 0);
        lit24("prec", 6, 0, 0);
        pulses("prec", 0, 0);

        // 12-hour set sequence through noon and back to midnight.
        do_reset();
        steps(11, 0, 0, 0, 1);
        steps(7, 0, 0, 1, 0);
        lit12("hrset_11am", 11, 7, 0, 0);
        step(0, 0, 0, 1);
        lit12("hrset_noon", 12, 7, 0, 1);
        lit24("hrset_noon", 12, 7, 0);
        pulses("hrset_noon", 0, 0);
        steps(12, 0, 0, 0, 1);
        lit12("hrset_midnight", 12, 7, 0, 0);
        lit24("hrset_midnight", 0, 7, 0);
        pulses("hrset_midnight", 0, 0);

        // Asynchronous clear mid-count at 07:42:13 PM with a TICK pending.
        do_reset();
        steps(19, 0, 0, 0, 1);
        steps(42, 0, 0, 1, 0);
        steps(13, 1, 1, 0, 0);
        lit12("pre_clear", 7, 42, 13, 1);
        lit24("pre_clear", 19, 42, 13);
        @(posedge CLK); #1;
        drive(1, 1, 0, 0);
        #1 CLEAR = 1'b0;
        #1;
        lit12("clear_async", 12, 0, 0, 0);
        lit24("clear_async", 0, 0, 0);
        pulses("clear_async", 0, 0);
        @(negedge CLK); #1;
        lit12("clear_edge", 12, 0, 0, 0);
        pulses("clear_edge", 0, 0);
        @(posedge CLK); #1;
        drive(0, 0, 0, 0);
        #2 CLEAR = 1'b1;
        step(1, 1, 0, 0);
        lit12("resume", 12, 0, 1, 0);
        lit24("resume", 0, 0, 1);
        step(0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
